// File: rtl/pcm_to_i2s_pkg.sv
// Framing constants and types shared by pcm_to_i2s and i2s_to_pcm so both directions
// agree on slot/frame geometry.
package pcm_to_i2s_pkg;

   localparam int NUMBER_OF_BITS = 8;
   localparam int SLOT_BITS      = 16;
   localparam int FRAME_BITS     = 2 * SLOT_BITS;
   localparam int CNT_W          = $clog2(FRAME_BITS);
   localparam int POS_W          = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
   localparam int IDX_W          = (NUMBER_OF_BITS > 1) ? $clog2(NUMBER_OF_BITS) : 1;

   typedef logic [NUMBER_OF_BITS-1:0] pcm_word_t;

   typedef struct packed {
      pcm_word_t left;
      pcm_word_t right;
   } pcm_pair_t;

endpackage

// File: rtl/pcm_to_i2s_frame_counter.sv
// I2S frame timebase: free-running bit counter with ws, slot position, frame start and
// last-cycle strobe. Kept standalone so the receive path can share the same ws timing.
module i2s_frame_counter
   import pcm_to_i2s_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   output logic             ws,
   output logic [POS_W-1:0] slot_pos,
   output logic             frame_start,
   output logic             last_cycle
);

   logic [CNT_W-1:0] bit_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bit_cnt <= '0;
      else if (last_cycle)
         bit_cnt <= '0;
      else
         bit_cnt <= bit_cnt + 1'b1;
   end

   always_comb begin
      ws          = (bit_cnt >= CNT_W'(SLOT_BITS));
      slot_pos    = ws ? POS_W'(bit_cnt - CNT_W'(SLOT_BITS)) : POS_W'(bit_cnt);
      frame_start = (bit_cnt == '0);
      last_cycle  = (bit_cnt == CNT_W'(FRAME_BITS - 1));
   end

endmodule

// File: rtl/pcm_to_i2s.sv
// Transmit-side I2S serializer with a one-deep valid/ready holding buffer.
// Define PCM_TO_I2S_HOLD_LAST_EN to repeat the last pair on underrun instead of sending silence.
module pcm_to_i2s
   import pcm_to_i2s_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUMBER_OF_BITS-1:0] pcm_left,
   input  logic [NUMBER_OF_BITS-1:0] pcm_right,
   input  logic                      sample_valid,
   output logic                      sample_ready,
   output logic                      sd_out,
   output logic                      ws_out,
   output logic                      frame_start,
   output logic                      underrun
);

`ifdef PCM_TO_I2S_HOLD_LAST_EN
   localparam bit HOLD_LAST = 1'b1;
`else
   localparam bit HOLD_LAST = 1'b0;
`endif

   generate
      if (SLOT_BITS < NUMBER_OF_BITS + 1) begin : g_bad_slot
         $error("SLOT_BITS must be at least NUMBER_OF_BITS+1");
      end
   endgenerate

   logic             ws;
   logic [POS_W-1:0] slot_pos;
   logic             last_cycle;
   pcm_pair_t        hold;
   pcm_pair_t        tx;
   logic             hold_full;
   logic             accept;
   pcm_word_t        cur_word;
   logic [IDX_W-1:0] bit_idx;

   i2s_frame_counter u_frame_counter (
      .clk         (clk),
      .reset       (reset),
      .ws          (ws),
      .slot_pos    (slot_pos),
      .frame_start (frame_start),
      .last_cycle  (last_cycle)
   );

   assign sample_ready = !hold_full;
   assign accept       = sample_valid && !hold_full;
   assign underrun     = last_cycle && !hold_full;
   assign ws_out       = ws;

   // The boundary transfer empties the buffer; an accept in that same cycle is only
   // possible when it was already empty, so the two never collide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold      <= '0;
         tx        <= '0;
         hold_full <= 1'b0;
      end else begin
         if (last_cycle) begin
            if (hold_full)
               tx <= hold;
            else if (!HOLD_LAST)
               tx <= '0;
         end
         if (last_cycle && hold_full) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold.left  <= pcm_left;
            hold.right <= pcm_right;
            hold_full  <= 1'b1;
         end
      end
   end

   // Slot position 0 is the I2S delay bit; positions past the word are zero padding.
   always_comb begin
      cur_word = ws ? tx.right : tx.left;
      bit_idx  = '0;
      sd_out   = 1'b0;
      if (slot_pos != '0 && int'(slot_pos) <= NUMBER_OF_BITS) begin
         bit_idx = IDX_W'(NUMBER_OF_BITS - int'(slot_pos));
         sd_out  = cur_word[bit_idx];
      end
   end

endmodule
